// File: rtl/alu_sequencer.sv
// Sequences ALU selector codes 0..NUM_OPS-1 over latched operands and
// collects each result into a 16-entry buffer that can be read back at any time.
module alu_sequencer #(
   parameter int WIDTH   = 8,
   parameter int NUM_OPS = 15,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   output logic             busy,
   output logic             done,
   input  logic             rd_en,
   input  logic [3:0]       rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [2:0] LAT_LAST = 3'(ALU_LAT);
   localparam logic [3:0] SEL_LAST = 4'(NUM_OPS - 1);

   logic [1:0]       state;
   logic [2:0]       cnt;
   logic [WIDTH-1:0] buffer [16];

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= '0;
         rd_data <= '0;
         for (int i = 0; i < 16; i++) buffer[i] <= '0;
      end else begin
         // Read sees the pre-edge contents, so a same-edge write returns old data
         if (rd_en) rd_data <= buffer[rd_addr];
         case (state)
            IDLE: if (start) begin
               alu_a   <= op_a;
               alu_b   <= op_b;
               alu_sel <= '0;
               cnt     <= '0;
               state   <= RUN;
            end
            RUN: if (cnt == LAT_LAST) begin
               buffer[alu_sel] <= alu_out;
               cnt             <= '0;
               if (alu_sel == SEL_LAST) state <= DONE;
               else                     alu_sel <= alu_sel + 4'd1;
            end else begin
               cnt <= cnt + 3'd1;
            end
            DONE: begin
               alu_sel <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: default instance plus an ALU_LAT=2, NUM_OPS=4
// instance, each driven by a registered A+B+sel ALU stub.
module tb_alu_sequencer;

   logic       clk = 0;
   logic       reset_n;
   logic       start, start2;
   logic [7:0] op_a, op_b, op_a2, op_b2;
   logic [7:0] alu_a, alu_b, alu_out, alu_a2, alu_b2, alu_out2;
   logic [3:0] alu_sel, alu_sel2, rd_addr, rd_addr2;
   logic       busy, done, busy2, done2, rd_en, rd_en2;
   logic [7:0] rd_data, rd_data2;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
      .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   alu_sequencer #(.WIDTH(8), .NUM_OPS(4), .ALU_LAT(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .op_a(op_a2), .op_b(op_b2),
      .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2), .alu_out(alu_out2),
      .busy(busy2), .done(done2), .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2)
   );

   always_ff @(posedge clk) begin
      alu_out  <= alu_a + alu_b + 8'(alu_sel);
      alu_out2 <= alu_a2 + alu_b2 + 8'(alu_sel2);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs dut for a fixed window after its start edge; drops start on done.
   task automatic watch_run(input int mid_a, output int nb, output int nd, output int a_bad);
      nb = 0; nd = 0; a_bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) nb++;
         if (busy && alu_a !== 8'd5) a_bad++;
         if (done) begin nd++; start = 0; end
         if (i == 10 && mid_a >= 0) op_a = 8'(mid_a);
         tick();
      end
   endtask

   task automatic read1(input int addr, input int exp, input string tag);
      rd_en = 1; rd_addr = 4'(addr);
      tick();
      chk(tag, 32'(rd_data), 32'(exp));
   endtask

   int nb, nd, a_bad;

   initial begin
      reset_n = 0; start = 0; start2 = 0; rd_en = 0; rd_en2 = 0;
      rd_addr = 0; rd_addr2 = 0; op_a = 0; op_b = 0; op_a2 = 0; op_b2 = 0;
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_alu_a", 32'(alu_a), 0);
      chk("rst_alu_b", 32'(alu_b), 0);
      chk("rst_alu_sel", 32'(alu_sel), 0);
      chk("rst_rd_data", 32'(rd_data), 0);

      // Basic run with start held through RUN and op_a disturbed mid-run
      reset_n = 1; op_a = 5; op_b = 2; start = 1;
      tick();
      chk("start_alu_a", 32'(alu_a), 5);
      chk("start_alu_b", 32'(alu_b), 2);
      chk("start_sel", 32'(alu_sel), 0);
      watch_run(9, nb, nd, a_bad);
      chk("run1_busy_cycles", 32'(nb), 30);
      chk("run1_done_pulses", 32'(nd), 1);
      chk("run1_alu_a_held", 32'(a_bad), 0);
      chk("run1_idle_busy", 32'(busy), 0);
      chk("run1_idle_sel", 32'(alu_sel), 0);
      chk("run1_alu_a_last", 32'(alu_a), 5);
      for (int k = 0; k < 16; k++) read1(k, (k < 15) ? 7 + k : 0, $sformatf("run1_buf%0d", k));
      read1(3, 10, "rd_addr3");
      rd_en = 0; rd_addr = 5;
      tick();
      chk("rd_hold", 32'(rd_data), 10);
      read1(15, 0, "rd_addr15");

      // Second run: read each entry on its own write edge, expect previous-run value
      op_a = 10; op_b = 0; start = 1;
      tick();
      start = 0;
      for (int e = 1; e <= 30; e++) begin
         rd_en = 1; rd_addr = 4'((e - 1) / 2);
         tick();
         if (e % 2 == 0) chk($sformatf("same_edge_rd%0d", e / 2 - 1), 32'(rd_data), 32'(7 + e / 2 - 1));
      end
      chk("run2_done", 32'(done), 1);
      tick();
      for (int k = 0; k < 16; k++) read1(k, (k < 15) ? 10 + k : 0, $sformatf("run2_buf%0d", k));

      // Reset at cycle 10 of a run, then restart immediately
      op_a = 5; op_b = 2; start = 1; rd_en = 0;
      tick();
      start = 0;
      nd = 0;
      for (int i = 1; i < 10; i++) begin
         if (done) nd++;
         tick();
      end
      reset_n = 0;
      tick();
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done + nd), 0);
      chk("mid_rst_alu_a", 32'(alu_a), 0);
      chk("mid_rst_alu_b", 32'(alu_b), 0);
      chk("mid_rst_sel", 32'(alu_sel), 0);
      chk("mid_rst_rd_data", 32'(rd_data), 0);
      reset_n = 1; start = 1; rd_en = 1; rd_addr = 3;
      tick();
      chk("post_rst_busy", 32'(busy), 1);
      chk("post_rst_buf3", 32'(rd_data), 0);
      rd_addr = 14;
      tick();
      chk("post_rst_buf14", 32'(rd_data), 0);
      rd_en = 0;
      watch_run(-1, nb, nd, a_bad);
      chk("run3_busy_cycles", 32'(nb + 1), 30);
      chk("run3_done_pulses", 32'(nd), 1);
      for (int k = 0; k < 16; k++) read1(k, (k < 15) ? 7 + k : 0, $sformatf("run3_buf%0d", k));
      rd_en = 0;

      // Latency-2, four-op instance
      op_a2 = 1; op_b2 = 1; start2 = 1;
      tick();
      start2 = 0;
      nb = 0; nd = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy2) nb++;
         if (done2) nd++;
         tick();
      end
      chk("lat2_busy_cycles", 32'(nb), 12);
      chk("lat2_done_pulses", 32'(nd), 1);
      for (int k = 0; k < 16; k++) begin
         rd_en2 = 1; rd_addr2 = 4'(k);
         tick();
         chk($sformatf("lat2_buf%0d", k), 32'(rd_data2), (k < 4) ? 32'(2 + k) : 0);
      end
      rd_en2 = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width.
REQ-002 SHALL have parameter NUM_OPS, default 15: ALU selector codes issued per run, 1..16.
REQ-003 SHALL have parameter ALU_LAT, default 1: clock edges from alu_sel change to valid alu_out, 1..4.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have port start  in  1  begin a run; sampled only in IDLE.
REQ-007 SHALL have port op_a  in  WIDTH  operand A, captured at start.
REQ-008 SHALL have port op_b  in  WIDTH  operand B, captured at start.
REQ-009 SHALL have port alu_a  out  WIDTH  registered operand A to the ALU.
REQ-010 SHALL have port alu_b  out  WIDTH  registered operand B to the ALU.
REQ-011 SHALL have port alu_sel  out  4  registered ALU selector.
REQ-012 SHALL have port alu_out  in  WIDTH  ALU result.
REQ-013 SHALL have port busy  out  1  high while a run is in progress.
REQ-014 SHALL have port done  out  1  one-cycle pulse at run completion.
REQ-015 SHALL have port rd_en  in  1  result-buffer read strobe.
REQ-016 SHALL have port rd_addr  in  4  result-buffer read address.
REQ-017 SHALL have port rd_data  out  WIDTH  registered read data.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after the last capture; DONE->IDLE unconditionally next edge.
REQ-019 SHALL, on the IDLE edge with start=1, load alu_a=op_a, alu_b=op_b, alu_sel=0, wait counter=0.
REQ-020 SHALL hold each alu_sel value for ALU_LAT+1 cycles, then write alu_out into buffer[alu_sel] and increment alu_sel on the same edge.
REQ-021 SHALL issue codes 0..NUM_OPS-1 in order, giving busy=1 for exactly NUM_OPS*(ALU_LAT+1) cycles.
REQ-022 SHALL hold alu_a/alu_b constant during RUN; op_a/op_b changes in RUN have no effect.
REQ-023 SHALL ignore start in RUN and DONE (no restart, no queueing).
REQ-024 SHALL assert done=1 only in DONE, busy=0 in DONE; alu_sel returns to 0 on entry to IDLE; alu_a/alu_b hold last values.
REQ-025 SHALL provide a 16 x WIDTH result buffer; entries >= NUM_OPS never written, read as 0.
REQ-026 SHALL return buffer[rd_addr] on rd_data one cycle after rd_en=1; rd_data holds when rd_en=0.
REQ-027 SHALL allow reads in any state; read of an address written on the same edge returns the old value.
REQ-028 SHALL retain buffer contents across runs; entries are overwritten only when reissued.

Reset
REQ-029 SHALL, with reset_n=0 at a rising edge, force state IDLE, busy=0, done=0, alu_a=0, alu_b=0, alu_sel=0, rd_data=0, wait counter=0, all buffer entries=0.
REQ-030 SHALL abort a run on reset mid-RUN with no done pulse; reset_n has priority over start.
REQ-031 SHALL accept start on the first edge after reset_n returns high.

Verification
REQ-032 SHALL cover: bench ALU stub Out<=A+B+sel (registered, ALU_LAT=1), op_a=5, op_b=2, start pulse -> busy 30 cycles, done one pulse, buffer[0..14]=7..21, buffer[15]=0.
REQ-033 SHALL cover: after REQ-032, rd_en with rd_addr=3 -> rd_data=10 next cycle; rd_addr=15 -> 0.
REQ-034 SHALL cover: start=1 held during RUN and op_a changed to 9 mid-run -> single run, alu_a stays 5, results unchanged.
REQ-035 SHALL cover: reset_n=0 at cycle 10 of a run -> busy=0, no done, all outputs and buffer 0, start next cycle runs normally.
REQ-036 SHALL cover: ALU_LAT=2, NUM_OPS=4, op_a=1, op_b=1 -> busy 12 cycles, buffer[0..3]=2..5, buffer[4..15]=0.
REQ-037 SHALL cover: second run op_a=10, op_b=0 after REQ-032 -> buffer[0..14]=10..24; read of buffer[k] on its write edge returns previous-run value.
